// File: rtl/coef_collector.sv
// Collects saturated coefficients from the sum pipeline into two ping-pong row buffers
// and hands complete rows downstream over a valid/ready handshake.
module coef_collector #(
    parameter int  WORD_LEN   = 16,
    parameter int  MATRIX_DIM = 4,
    localparam int ROW_W      = WORD_LEN * MATRIX_DIM,
    localparam int IDX_W      = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1
) (
    input  logic                    src_clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    we_in,
    input  logic signed [ROW_W-1:0] COEF_IN,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic [ROW_W-1:0]        ROW_OUT,
    output logic [IDX_W-1:0]        row_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(MATRIX_DIM - 1);

    state_t state, state_next;

    logic [WORD_LEN-1:0] row_buf [2][MATRIX_DIM];
    logic [IDX_W-1:0]    row_tag [2];
    logic [1:0]          buf_full;
    logic                fill_sel;
    logic                rd_sel;
    logic [IDX_W-1:0]    col;
    logic [IDX_W-1:0]    row_cnt;

    logic start_ok, capture, write_en, row_end, last_row_end, accept, last_accept;

    // Clamp a full-precision coefficient into signed WORD_LEN range.
    function automatic logic [WORD_LEN-1:0] saturate(input logic signed [ROW_W-1:0] value);
        logic [ROW_W-WORD_LEN:0] upper;
        upper = value[ROW_W-1:WORD_LEN-1];
        if (upper == '0 || upper == '1)
            return value[WORD_LEN-1:0];
        else if (value[ROW_W-1])
            return {1'b1, {(WORD_LEN-1){1'b0}}};
        else
            return {1'b0, {(WORD_LEN-1){1'b1}}};
    endfunction

    // The fill buffer can only be full when both are, since drains follow fill order.
    assign start_ok     = (state == IDLE) && start;
    assign capture      = (state == COLLECT) && we_in;
    assign write_en     = capture && !buf_full[fill_sel];
    assign row_end      = write_en && (col == LAST);
    assign last_row_end = row_end && (row_cnt == LAST);
    assign row_valid    = buf_full[rd_sel];
    assign accept       = row_valid && row_ready;
    assign last_accept  = accept && (state == DRAIN) && (row_tag[rd_sel] == LAST);

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        unique case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: begin
                busy = 1'b1;
                if (last_row_end) state_next = DRAIN;
            end
            DRAIN:   if (last_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                row_tag[b] <= '0;
                for (int c = 0; c < MATRIX_DIM; c++)
                    row_buf[b][c] <= '0;
            end
            buf_full <= '0;
            fill_sel <= 1'b0;
            rd_sel   <= 1'b0;
            col      <= '0;
            row_cnt  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= last_accept;
            if (start_ok) begin
                buf_full <= '0;
                fill_sel <= 1'b0;
                rd_sel   <= 1'b0;
                col      <= '0;
                row_cnt  <= '0;
                overflow <= 1'b0;
            end else begin
                if (accept) begin
                    buf_full[rd_sel] <= 1'b0;
                    rd_sel           <= ~rd_sel;
                end
                if (capture && buf_full[fill_sel])
                    overflow <= 1'b1;
                if (write_en) begin
                    row_buf[fill_sel][col] <= saturate(COEF_IN);
                    if (row_end) begin
                        buf_full[fill_sel] <= 1'b1;
                        row_tag[fill_sel]  <= row_cnt;
                        col                <= '0;
                        fill_sel           <= ~fill_sel;
                        row_cnt            <= row_cnt + IDX_W'(1);
                    end else begin
                        col <= col + IDX_W'(1);
                    end
                end
            end
        end
    end

    // Outputs read as zero whenever no row is presented.
    always_comb begin
        ROW_OUT = '0;
        row_idx = '0;
        if (row_valid) begin
            for (int c = 0; c < MATRIX_DIM; c++)
                ROW_OUT[c*WORD_LEN +: WORD_LEN] = row_buf[rd_sel][c];
            row_idx = row_tag[rd_sel];
        end
    end

endmodule

// File: tb/tb_coef_collector.sv
// Self-checking bench for coef_collector: queue-based reference model compared every cycle,
// plus directed scenarios pinned to hand-computed rows.
module tb_coef_collector;

    localparam int WORD_LEN   = 16;
    localparam int MATRIX_DIM = 4;
    localparam int ROW_W      = WORD_LEN * MATRIX_DIM;
    localparam int IDX_W      = 2;
    localparam int M_IDLE     = 0;
    localparam int M_COLLECT  = 1;
    localparam int M_DRAIN    = 2;

    logic                    src_clk   = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    start     = 1'b0;
    logic                    we_in     = 1'b0;
    logic signed [ROW_W-1:0] coef_in   = '0;
    logic                    row_ready = 1'b0;
    logic                    row_valid;
    logic [ROW_W-1:0]        row_out;
    logic [IDX_W-1:0]        row_idx;
    logic                    busy, done, overflow;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: pending complete rows in delivery order, plus the row being assembled.
    logic [ROW_W-1:0]    m_q[$];
    int                  m_idx_q[$];
    logic [ROW_W-1:0]    m_log[$];
    logic [WORD_LEN-1:0] m_partial [MATRIX_DIM];
    int                  m_mode = M_IDLE;
    int                  m_col  = 0;
    int                  m_rows = 0;
    bit                  m_ovf  = 1'b0;
    bit                  m_done = 1'b0;

    logic [ROW_W-1:0] dut_log[$];
    int               dut_idx_log[$];
    int               hs_cycles[$];
    int               valid_cycles[$];
    int               done_cycles[$];

    coef_collector #(.WORD_LEN(WORD_LEN), .MATRIX_DIM(MATRIX_DIM)) dut (
        .src_clk  (src_clk),
        .rst_n    (rst_n),
        .start    (start),
        .we_in    (we_in),
        .COEF_IN  (coef_in),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .ROW_OUT  (row_out),
        .row_idx  (row_idx),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 src_clk = ~src_clk;

    function automatic logic [WORD_LEN-1:0] sat_model(input longint v);
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< (WORD_LEN - 1)) - 1;
        minv = -(longint'(1) <<< (WORD_LEN - 1));
        if (v > maxv) return maxv[WORD_LEN-1:0];
        if (v < minv) return minv[WORD_LEN-1:0];
        return v[WORD_LEN-1:0];
    endfunction

    function automatic longint rand_value();
        case ($urandom_range(0, 3))
            0:       return longint'({$urandom, $urandom});
            1:       return longint'($urandom_range(0, 80000)) - 40000;
            default: return longint'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [ROW_W-1:0] actual,
                                input logic [ROW_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_idx_q.delete();
        m_mode = M_IDLE;
        m_col  = 0;
        m_rows = 0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
    endtask

    // Advances the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int               mode_now;
        int               pending;
        logic [ROW_W-1:0] packed_row;
        if (!rst_n) begin
            model_reset();
            return;
        end
        mode_now = m_mode;
        pending  = m_q.size();
        m_done   = 1'b0;
        if (pending > 0 && row_ready) begin
            if (mode_now == M_DRAIN && m_idx_q[0] == MATRIX_DIM - 1) begin
                m_done = 1'b1;
                m_mode = M_IDLE;
            end
            m_log.push_back(m_q[0]);
            void'(m_q.pop_front());
            void'(m_idx_q.pop_front());
        end
        if (mode_now == M_IDLE && start) begin
            m_mode = M_COLLECT;
            m_col  = 0;
            m_rows = 0;
            m_ovf  = 1'b0;
        end else if (mode_now == M_COLLECT && we_in) begin
            if (pending == 2) begin
                m_ovf = 1'b1;
            end else begin
                m_partial[m_col] = sat_model(coef_in);
                m_col++;
                if (m_col == MATRIX_DIM) begin
                    for (int c = 0; c < MATRIX_DIM; c++)
                        packed_row[c*WORD_LEN +: WORD_LEN] = m_partial[c];
                    m_q.push_back(packed_row);
                    m_idx_q.push_back(m_rows);
                    m_rows++;
                    m_col = 0;
                    if (m_rows == MATRIX_DIM) m_mode = M_DRAIN;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge src_clk);
        model_step();
        #1;
    endtask

    task automatic apply_stimulus(input bit s, input bit we, input longint v);
        start   = s;
        we_in   = we;
        coef_in = v;
        tick();
        start = 1'b0;
        we_in = 1'b0;
    endtask

    task automatic clear_logs();
        dut_log.delete();
        dut_idx_log.delete();
        hs_cycles.delete();
        valid_cycles.delete();
        done_cycles.delete();
        m_log.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check_output(name, ROW_W'(seen), ROW_W'(1));
        tick();
    endtask

    task automatic check_log_row(input string name, input int i, input logic [ROW_W-1:0] exp_row);
        check_output({name, "_present"}, ROW_W'(dut_log.size() > i), ROW_W'(1));
        if (dut_log.size() > i) begin
            check_output({name, "_dut_row"}, dut_log[i], exp_row);
            check_output({name, "_dut_idx"}, ROW_W'(dut_idx_log[i]), ROW_W'(i));
        end
        if (m_log.size() > i)
            check_output({name, "_model_row"}, m_log[i], exp_row);
    endtask

    // Every cycle: DUT outputs against the model, plus handshake bookkeeping.
    always @(negedge src_clk) begin
        check_output("row_valid", ROW_W'(row_valid), ROW_W'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check_output("row_out", row_out, m_q[0]);
            check_output("row_idx", ROW_W'(row_idx), ROW_W'(m_idx_q[0]));
        end else if (!rst_n) begin
            check_output("row_out_reset", row_out, '0);
            check_output("row_idx_reset", ROW_W'(row_idx), '0);
        end
        check_output("busy", ROW_W'(busy), ROW_W'(m_mode == M_COLLECT));
        check_output("done", ROW_W'(done), ROW_W'(m_done));
        check_output("overflow", ROW_W'(overflow), ROW_W'(m_ovf));
        if (row_valid && row_ready) begin
            dut_log.push_back(row_out);
            dut_idx_log.push_back(int'(row_idx));
            hs_cycles.push_back(cycle);
        end
        if (row_valid) valid_cycles.push_back(cycle);
        if (done) done_cycles.push_back(cycle);
        cycle <= cycle + 1;
    end

    initial begin
        check_output("sat_model_pos", ROW_W'(sat_model(40000)), ROW_W'(16'h7FFF));
        check_output("sat_model_neg", ROW_W'(sat_model(-40000)), ROW_W'(16'h8000));
        for (int i = 0; i < 3; i++) tick();
        check_output("rst_row_valid", ROW_W'(row_valid), '0);
        check_output("rst_busy", ROW_W'(busy), '0);
        check_output("rst_overflow", ROW_W'(overflow), '0);
        rst_n = 1'b1;
        tick();

        // Basic matrix, downstream always ready.
        $display("[TB] basic collection");
        row_ready = 1'b1;
        clear_logs();
        apply_stimulus(1, 0, 0);
        for (int v = 1; v <= 16; v++) apply_stimulus(0, 1, v);
        wait_done("basic_done", 50);
        check_output("basic_rows", ROW_W'(dut_log.size()), ROW_W'(4));
        check_log_row("basic_r0", 0, 64'h0004_0003_0002_0001);
        check_log_row("basic_r1", 1, 64'h0008_0007_0006_0005);
        check_log_row("basic_r2", 2, 64'h000C_000B_000A_0009);
        check_log_row("basic_r3", 3, 64'h0010_000F_000E_000D);
        check_output("basic_done_latency",
                     ROW_W'((done_cycles.size() > 0 && hs_cycles.size() > 0) ?
                            done_cycles[$] - hs_cycles[$] : -1), ROW_W'(1));

        // Saturation of out-of-range coefficients.
        $display("[TB] saturation");
        clear_logs();
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 1, 40000);
        apply_stimulus(0, 1, -40000);
        apply_stimulus(0, 1, 32767);
        apply_stimulus(0, 1, -5);
        for (int v = 0; v < 12; v++) apply_stimulus(0, 1, v);
        wait_done("sat_done", 50);
        check_log_row("sat_r0", 0, 64'hFFFB_7FFF_8000_7FFF);

        // Backpressure: two rows held, ninth strobe dropped.
        $display("[TB] backpressure");
        row_ready = 1'b0;
        clear_logs();
        apply_stimulus(1, 0, 0);
        for (int v = 101; v <= 108; v++) apply_stimulus(0, 1, v);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("bp_stable_row", row_out, 64'h0068_0067_0066_0065);
            check_output("bp_stable_idx", ROW_W'(row_idx), '0);
        end
        apply_stimulus(0, 1, 999);
        check_output("bp_overflow", ROW_W'(overflow), ROW_W'(1));
        check_output("bp_row_held", row_out, 64'h0068_0067_0066_0065);
        row_ready = 1'b1;
        tick();
        tick();
        for (int v = 109; v <= 116; v++) apply_stimulus(0, 1, v);
        wait_done("bp_done", 50);
        check_log_row("bp_r0", 0, 64'h0068_0067_0066_0065);
        check_log_row("bp_r1", 1, 64'h006C_006B_006A_0069);
        check_log_row("bp_r2", 2, 64'h0070_006F_006E_006D);
        check_output("bp_overflow_sticky", ROW_W'(overflow), ROW_W'(1));

        // Back-to-back strobes: one valid row every four cycles.
        $display("[TB] fill/drain overlap");
        clear_logs();
        apply_stimulus(1, 0, 0);
        check_output("ovl_overflow_cleared", ROW_W'(overflow), '0);
        for (int v = 1; v <= 16; v++) apply_stimulus(0, 1, v * 3);
        wait_done("ovl_done", 50);
        check_output("ovl_valid_count", ROW_W'(valid_cycles.size()), ROW_W'(4));
        for (int i = 1; i < valid_cycles.size(); i++)
            check_output("ovl_valid_spacing", ROW_W'(valid_cycles[i] - valid_cycles[i-1]), ROW_W'(4));
        check_output("ovl_overflow", ROW_W'(overflow), '0);

        // Reset in the middle of a row with an unsent row pending.
        $display("[TB] reset mid-row");
        row_ready = 1'b0;
        clear_logs();
        apply_stimulus(1, 0, 0);
        for (int v = 1; v <= 6; v++) apply_stimulus(0, 1, v + 50);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("mid_rst_valid", ROW_W'(row_valid), '0);
        check_output("mid_rst_row", row_out, '0);
        check_output("mid_rst_idx", ROW_W'(row_idx), '0);
        check_output("mid_rst_busy", ROW_W'(busy), '0);
        check_output("mid_rst_done", ROW_W'(done), '0);
        check_output("mid_rst_overflow", ROW_W'(overflow), '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        apply_stimulus(0, 1, 5);
        apply_stimulus(0, 1, 6);
        row_ready = 1'b1;
        clear_logs();
        apply_stimulus(1, 0, 0);
        for (int v = 201; v <= 216; v++) apply_stimulus(0, 1, v);
        wait_done("rst_done", 50);
        check_output("rst_rows", ROW_W'(dut_log.size()), ROW_W'(4));
        check_log_row("rst_r0", 0, 64'h00CC_00CB_00CA_00C9);
        check_log_row("rst_r3", 3, 64'h00D8_00D7_00D6_00D5);

        // Spurious strobes in IDLE and a start during COLLECT.
        $display("[TB] spurious inputs");
        clear_logs();
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 7777);
        check_output("spur_idle_overflow", ROW_W'(overflow), '0);
        apply_stimulus(1, 0, 0);
        for (int v = 1; v <= 4; v++) apply_stimulus(0, 1, v);
        apply_stimulus(1, 0, 0);
        apply_stimulus(1, 1, 5);
        for (int v = 6; v <= 16; v++) apply_stimulus(0, 1, v);
        wait_done("spur_done", 50);
        check_log_row("spur_r0", 0, 64'h0004_0003_0002_0001);
        check_log_row("spur_r1", 1, 64'h0008_0007_0006_0005);
        check_log_row("spur_r3", 3, 64'h0010_000F_000E_000D);
        check_output("spur_overflow", ROW_W'(overflow), '0);

        // Randomized matrices with random strobes, values and backpressure.
        $display("[TB] randomized");
        for (int m = 0; m < 8; m++) begin
            int  ready_pct;
            bit  finished;
            ready_pct = $urandom_range(15, 100);
            finished  = 1'b0;
            apply_stimulus(1, 0, 0);
            for (int c = 0; c < 3000 && !finished; c++) begin
                row_ready = ($urandom_range(1, 100) <= ready_pct);
                apply_stimulus($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, rand_value());
                if (done) finished = 1'b1;
            end
            check_output("rand_done", ROW_W'(finished), ROW_W'(1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
